// File: rtl/svo_term_bridge_pkg.sv
// Shared constants for the terminal bridge: register map, STATUS/CTRL bit
// positions and the bus FSM encoding.
package svo_term_bridge_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_LEVEL_W = 9;
  localparam int ST_EMPTY   = 16;
  localparam int ST_FULL    = 17;
  localparam int ST_OVF     = 18;

  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    BUS_STALL = 2'd1,
    BUS_ACK   = 2'd2
  } bus_state_e;

  function automatic logic [31:0] pack_status(input logic [ST_LEVEL_W-1:0] level,
                                              input logic empty, input logic full,
                                              input logic ovf);
    logic [31:0] s;
    s = '0;
    s[ST_LEVEL_W-1:0] = level;
    s[ST_EMPTY]       = empty;
    s[ST_FULL]        = full;
    s[ST_OVF]         = ovf;
    return s;
  endfunction

endpackage

// File: rtl/svo_sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers; a push into a full FIFO
// is accepted when a pop frees the slot in the same cycle.
module svo_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign level   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Gate the head so the stream byte reads zero whenever nothing is queued.
  assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/svo_term_bridge.sv
// picorv32 bus slave that queues terminal characters and drains them as a
// valid/ready byte stream toward the HDMI terminal.
module svo_term_bridge
  import svo_term_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH    = 16,
  parameter int BLOCK_ON_FULL = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        term_out_tvalid,
  input  logic        term_out_tready,
  output logic [7:0]  term_out_tdata
);

  localparam int AW = $clog2(FIFO_DEPTH);

  bus_state_e  state, state_n;
  logic        push_pend, push_pend_n;
  logic [7:0]  push_byte;
  logic        overflow, ovf_set, ovf_clr;
  logic [31:0] rdata_n;
  logic        stall_push, fifo_flush, fifo_push, fifo_pop;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_level;
  logic [7:0]  fifo_wdata;
  logic        hit, is_wr;
  logic [1:0]  rsel;
  logic        unused_bits;

  assign hit   = mem_valid & sel & ~mem_ready;
  assign is_wr = |mem_wstrb;
  assign rsel  = mem_addr[3:2];
  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:8], mem_wstrb[3:1]};

  assign mem_ready       = (state == BUS_ACK);
  assign term_out_tvalid = ~fifo_empty;
  assign fifo_pop        = term_out_tvalid & term_out_tready;
  assign fifo_push       = stall_push | push_pend;
  assign fifo_wdata      = push_pend ? push_byte : mem_wdata[7:0];

  always_comb begin
    state_n     = state;
    push_pend_n = 1'b0;
    stall_push  = 1'b0;
    fifo_flush  = 1'b0;
    ovf_set     = 1'b0;
    ovf_clr     = 1'b0;
    rdata_n     = '0;
    case (state)
      BUS_IDLE: if (hit) begin
        state_n = BUS_ACK;
        if (is_wr) begin
          case (rsel)
            REG_DATA: if (mem_wstrb[0]) begin
              if (!fifo_full)              push_pend_n = 1'b1;
              else if (BLOCK_ON_FULL != 0) state_n     = BUS_STALL;
              else                         ovf_set     = 1'b1;
            end
            REG_CTRL: begin
              fifo_flush = mem_wdata[CTRL_FLUSH];
              ovf_clr    = mem_wdata[CTRL_CLR_OVF];
            end
            default: ;
          endcase
        end else if (rsel == REG_STATUS) begin
          rdata_n = pack_status(ST_LEVEL_W'(fifo_level), fifo_empty, fifo_full, overflow);
        end
      end
      // Retry every cycle; a pop in this same cycle is enough to make room.
      BUS_STALL: begin
        if (!mem_valid) begin
          state_n = BUS_IDLE;
        end else if (!fifo_full || fifo_pop) begin
          stall_push = 1'b1;
          state_n    = BUS_ACK;
        end
      end
      BUS_ACK:  state_n = BUS_IDLE;
      default:  state_n = BUS_IDLE;
    endcase
  end

  // The accepted byte is pushed during the ack cycle, giving a fixed
  // two-cycle accept-to-tvalid latency on an empty FIFO.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= BUS_IDLE;
      push_pend <= 1'b0;
      push_byte <= '0;
      overflow  <= 1'b0;
      mem_rdata <= '0;
    end else begin
      state     <= state_n;
      push_pend <= push_pend_n;
      if (push_pend_n) push_byte <= mem_wdata[7:0];
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      mem_rdata <= rdata_n;
    end
  end

  svo_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .resetn(resetn),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .rdata (term_out_tdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
